// File: rtl/cp0_unit_pkg.sv
// Shared CP0 definitions: register numbers, exception codes, field layout
// and helpers that pack the architectural register images.
package cp0_unit_pkg;

  localparam logic [4:0] REG_SR    = 5'd12;
  localparam logic [4:0] REG_CAUSE = 5'd13;
  localparam logic [4:0] REG_EPC   = 5'd14;
  localparam logic [4:0] REG_PRID  = 5'd15;

  localparam logic [4:0] EXC_INT  = 5'd0;
  localparam logic [4:0] EXC_ADEL = 5'd4;
  localparam logic [4:0] EXC_ADES = 5'd5;
  localparam logic [4:0] EXC_RI   = 5'd10;
  localparam logic [4:0] EXC_OV   = 5'd12;

  localparam int SR_IE_BIT     = 0;
  localparam int SR_EXL_BIT    = 1;
  localparam int SR_IM_LSB     = 10;
  localparam int CAUSE_EXC_LSB = 2;
  localparam int CAUSE_IP_LSB  = 10;
  localparam int CAUSE_BD_BIT  = 31;

  typedef struct packed {
    logic [5:0] im;
    logic       exl;
    logic       ie;
  } sr_t;

  typedef struct packed {
    logic       bd;
    logic [5:0] ip;
    logic [4:0] exc_code;
  } cause_t;

  // Architectural SR image; unimplemented bits read as zero.
  function automatic logic [31:0] sr_word(sr_t s);
    logic [31:0] w;
    w = '0;
    w[SR_IM_LSB +: 6] = s.im;
    w[SR_EXL_BIT]     = s.exl;
    w[SR_IE_BIT]      = s.ie;
    return w;
  endfunction

  // Architectural Cause image; unimplemented bits read as zero.
  function automatic logic [31:0] cause_word(cause_t c);
    logic [31:0] w;
    w = '0;
    w[CAUSE_BD_BIT]         = c.bd;
    w[CAUSE_IP_LSB +: 6]    = c.ip;
    w[CAUSE_EXC_LSB +: 5]   = c.exc_code;
    return w;
  endfunction

endpackage

// File: rtl/cp0_unit_if.sv
// Pipeline-to-CP0 bus: mfc0/mtc0 access, M-stage exception info, redirect.
interface cp0_unit_if;
  logic [4:0]  A1;
  logic [4:0]  A2;
  logic [31:0] DIn;
  logic        WE;
  logic [31:0] PC;
  logic        BD_in;
  logic [6:2]  ExcCode_in;
  logic [7:2]  HWInt;
  logic        EXLClr;
  logic        IntReq;
  logic [31:0] handler_pc;
  logic [31:0] EPC_out;
  logic [31:0] DOut;

  modport master (
    output A1, A2, DIn, WE, PC, BD_in, ExcCode_in, HWInt, EXLClr,
    input  IntReq, handler_pc, EPC_out, DOut
  );

  modport slave (
    input  A1, A2, DIn, WE, PC, BD_in, ExcCode_in, HWInt, EXLClr,
    output IntReq, handler_pc, EPC_out, DOut
  );
endinterface

// File: rtl/cp0_unit_arbiter.sv
// Combinational exception/interrupt arbiter: decides whether to trap this
// cycle and which code to record. Interrupts outrank synchronous exceptions.
module cp0_exc_arbiter
  import cp0_unit_pkg::*;
(
  input  logic [7:2] hw_int,
  input  sr_t        sr,
  input  logic [6:2] exc_code_in,
  output logic       int_req,
  output logic [4:0] code
);

  logic int_pend;
  logic exc_pend;

  // Pending conditions are masked while already in the handler (EXL).
  always_comb begin
    int_pend = (|(hw_int & sr.im)) & sr.ie & ~sr.exl;
    exc_pend = (exc_code_in != '0) & ~sr.exl;
    int_req  = int_pend | exc_pend;
    code     = int_pend ? EXC_INT : exc_code_in;
  end

endmodule

// File: rtl/cp0_unit.sv
// CP0 register file (SR, Cause, EPC, PRId) with trap entry, eret and mtc0.
// All architectural state lives here; arbitration is in cp0_exc_arbiter.
module cp0_unit
  import cp0_unit_pkg::*;
#(
  parameter logic [31:0] PRID         = 32'h0000_7007,
  parameter logic [31:0] HANDLER_ADDR = 32'h0000_4180
)(
  input  logic     clk,
  input  logic     reset,
  cp0_unit_if.slave bus
);

  sr_t         sr_q;
  cause_t      cause_q;
  logic [31:0] epc_q;

  logic        int_req;
  logic [4:0]  chosen_code;
  logic [31:0] trap_pc;

  cp0_exc_arbiter u_arbiter (
    .hw_int      (bus.HWInt),
    .sr          (sr_q),
    .exc_code_in (bus.ExcCode_in),
    .int_req     (int_req),
    .code        (chosen_code)
  );

  assign bus.IntReq     = int_req;
  assign bus.handler_pc = HANDLER_ADDR;
  assign bus.EPC_out    = epc_q;

  // A delay-slot instruction restarts at its branch so eret re-executes it.
  assign trap_pc = (bus.BD_in ? bus.PC - 32'd4 : bus.PC) & ~32'd3;

  // Register state: reset, then trap entry, then mtc0 / eret.
  // NOTE: state registers use non-blocking assignments so every update in this
  // block sees the pre-edge values, matching the flop behaviour.
  always_ff @(posedge clk) begin
    if (reset) begin
      sr_q    <= '0;
      cause_q <= '0;
      epc_q   <= '0;
    end else begin
      cause_q.ip <= bus.HWInt;
      if (int_req) begin
        sr_q.exl         <= 1'b1;
        cause_q.exc_code <= chosen_code;
        cause_q.bd       <= bus.BD_in;
        epc_q            <= trap_pc;
      end else begin
        if (bus.WE) begin
          case (bus.A2)
            REG_SR: begin
              sr_q.im  <= bus.DIn[SR_IM_LSB +: 6];
              sr_q.exl <= bus.DIn[SR_EXL_BIT];
              sr_q.ie  <= bus.DIn[SR_IE_BIT];
            end
            REG_EPC: epc_q <= bus.DIn & ~32'd3;
            default: ;
          endcase
        end
        if (bus.EXLClr) sr_q.exl <= 1'b0;
      end
    end
  end

  // mfc0 read port; pure combinational view of the current registers.
  // NOTE: the default assignment first keeps this block from inferring a latch
  // for A1 values not listed in the case.
  always_comb begin
    bus.DOut = '0;
    case (bus.A1)
      REG_SR:    bus.DOut = sr_word(sr_q);
      REG_CAUSE: bus.DOut = cause_word(cause_q);
      REG_EPC:   bus.DOut = epc_q;
      REG_PRID:  bus.DOut = PRID;
      default:   bus.DOut = '0;
    endcase
  end

endmodule

// File: doc/cp0_unit.md
CP0_UNIT -- requirements
Module: cp0_unit

Interface
REQ-001 SHALL have parameter PRID, default 32'h0000_7007, the constant value returned for register 15.
REQ-002 SHALL have parameter HANDLER_ADDR, default 32'h0000_4180, the exception entry address driven on handler_pc.
REQ-003 clk  input  1  -- single clock; all state updates on rising edge.
REQ-004 reset  input  1  -- synchronous, active-high.
REQ-005 A1  input  5  -- mfc0 read register number.
REQ-006 A2  input  5  -- mtc0 write register number.
REQ-007 DIn  input  32  -- mtc0 write data.
REQ-008 WE  input  1  -- mtc0 write enable.
REQ-009 PC  input  32  -- PC of the instruction currently in the M stage.
REQ-010 BD_in  input  1  -- the M-stage instruction sits in a branch delay slot.
REQ-011 ExcCode_in  input  [6:2]  -- exception code from the M-stage ExcCode pipeline register; 0 means no exception.
REQ-012 HWInt  input  [7:2]  -- external hardware interrupt lines.
REQ-013 EXLClr  input  1  -- eret in M stage.
REQ-014 IntReq  output  1  -- flush pipeline and redirect to handler_pc.
REQ-015 handler_pc  output  32  -- always HANDLER_ADDR.
REQ-016 EPC_out  output  32  -- current EPC, for eret.
REQ-017 DOut  output  32  -- combinational read of register A1.

Function
REQ-018 SR (reg 12) SHALL hold IM[15:10], EXL[1] and IE[0]; all other bits SHALL read 0.
REQ-019 Cause (reg 13) SHALL hold BD[31], IP[15:10] and ExcCode[6:2]; all other bits SHALL read 0.
REQ-020 EPC (reg 14) SHALL hold 32 bits, with bits [1:0] forced to 0.
REQ-021 PRId (reg 15) SHALL read PRID.
REQ-022 DOut SHALL read 0 for any other A1 value.
REQ-023 int_pend SHALL be |(HWInt & SR.IM) & SR.IE & ~SR.EXL.
REQ-024 exc_pend SHALL be (ExcCode_in != 0) & ~SR.EXL.
REQ-025 IntReq SHALL be int_pend | exc_pend, combinational in the same cycle.
REQ-026 Priority: int_pend SHALL win over exc_pend; the recorded code is 0 on interrupt, else ExcCode_in.
REQ-027 On an IntReq edge the block SHALL:
  - set EXL <= 1;
  - set Cause.ExcCode <= the chosen code;
  - set Cause.BD <= BD_in;
  - set EPC <= (BD_in ? PC-4 : PC) & ~3.
REQ-028 Cause.IP SHALL sample HWInt every cycle, independent of IntReq and EXL.
REQ-029 WE=1 with IntReq=0 SHALL write DIn to register A2 on the edge:
  - reg 12: IM, EXL and IE fields;
  - reg 14: whole register, with [1:0] cleared;
  - regs 13 and 15: the write SHALL be ignored.
REQ-030 WE=1 with IntReq=1 in the same cycle: the write SHALL be discarded and the exception update SHALL win.
REQ-031 EXLClr=1 with IntReq=0 SHALL clear EXL on the edge.
REQ-032 EXLClr=1 with IntReq=1: IntReq SHALL win and EXL SHALL stay 1.
REQ-033 While EXL=1, nested interrupts and exceptions SHALL be ignored (IntReq=0).
REQ-034 Read-during-write: DOut SHALL return the old value in the write cycle and the new value from the next cycle.
REQ-035 EPC_out SHALL equal the EPC register with no bypass.

Reset
REQ-036 On reset=1 at an edge, SR, Cause and EPC SHALL all become 0.
REQ-037 Reset SHALL take priority over IntReq, WE and EXLClr.
REQ-038 During a reset cycle IntReq SHALL still evaluate combinationally, but no state SHALL change except clearing.
REQ-039 The cycle after reset, IntReq SHALL be 0 unless ExcCode_in != 0.

Structure
REQ-040 A shared package SHALL hold:
  - register numbers SR=12, CAUSE=13, EPC=14, PRID=15;
  - ExcCode constants Int=0, AdEL=4, AdES=5, RI=10, Ov=12;
  - field bit positions.
REQ-041 cp0_exc_arbiter SHALL be a combinational sub-module producing IntReq and the chosen code from HWInt, SR and ExcCode_in.
REQ-042 cp0_unit SHALL hold all state.

Verification
REQ-043 Reset → mtc0 SR=32'h0000_0401, HWInt=6'b000001, PC=32'h0000_3010, BD_in=0 → IntReq=1; next cycle EPC=32'h0000_3010, Cause.ExcCode=0, EXL=1, IntReq=0.
REQ-044 IE=0, ExcCode_in=12 (Ov), PC=32'h0000_3024, BD_in=1 → IntReq=1; then EPC=32'h0000_3020, Cause=32'h8000_0030.
REQ-045 HWInt enabled and ExcCode_in=10 in the same cycle → Cause.ExcCode=0.
REQ-046 WE=1, A2=14, DIn=32'h0000_3000 together with an exception → EPC equals the exception PC, not 32'h0000_3000.
REQ-047 EXL=1 with a new ExcCode_in=4 → IntReq=0 and Cause unchanged.
REQ-048 EXLClr=1 → the next cycle shows EXL=0, and a pending enabled interrupt raises IntReq.
REQ-049 Reset asserted while EXL=1 and HWInt active → SR, Cause and EPC read 0, except Cause.IP after the following cycle.
